// File: rtl/fpnew_opgroup_rr_arbiter.sv
// fpnew_opgroup_rr_arbiter: round-robin share of one FP opgroup slice by NumReq requesters (req_* issue in, slc_* slice side, rsp_* result out, flush_i, outstanding_o/busy_o status)
module fpnew_opgroup_rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned Width = 64,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned TagWidth = 4,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdW = $clog2(NumReq)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq*NumOperands*Width-1:0]  req_operands_i,
  input  logic [NumReq*4-1:0]                  req_op_i,
  input  logic [NumReq*3-1:0]                  req_rnd_mode_i,
  input  logic [NumReq-1:0]                    req_op_mod_i,
  input  logic [NumReq-1:0]                    req_vectorial_i,
  input  logic [NumReq*TagWidth-1:0]           req_tag_i,
  output logic                                 slc_valid_o,
  input  logic                                 slc_ready_i,
  output logic [NumOperands*Width-1:0]         slc_operands_o,
  output logic [3:0]                           slc_op_o,
  output logic [2:0]                           slc_rnd_mode_o,
  output logic                                 slc_op_mod_o,
  output logic                                 slc_vectorial_o,
  output logic [TagWidth+IdW-1:0]              slc_tag_o,
  input  logic                                 slc_out_valid_i,
  output logic                                 slc_out_ready_o,
  input  logic [Width-1:0]                     slc_result_i,
  input  logic [4:0]                           slc_status_i,
  input  logic [TagWidth+IdW-1:0]              slc_tag_i,
  output logic [NumReq-1:0]                    rsp_valid_o,
  input  logic [NumReq-1:0]                    rsp_ready_i,
  output logic [Width-1:0]                     rsp_result_o,
  output logic [4:0]                           rsp_status_o,
  output logic [TagWidth-1:0]                  rsp_tag_o,
  output logic [3:0]                           outstanding_o,
  output logic                                 busy_o
);
  localparam int unsigned IdN = 2**IdW;
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d, lock_q, lock_d, rr_idx, sel, k, id;
  logic [3:0] out_q, out_d;
  logic [IdN-1:0] oh;
  logic found, kill, full, gnt, issue, rsp_hs, dec, id_ok;
  always_comb begin
    found = 1'b0;
    rr_idx = '0;
    k = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      k = IdW'((32'(ptr_q) + i) % NumReq);
      if (!found && req_valid_i[k]) begin
        found = 1'b1;
        rr_idx = k;
      end
    end
  end
  assign kill  = flush_i | rst_i;
  assign full  = out_q == 4'(MaxOutstanding);
  assign sel   = state_q == LOCKED ? lock_q : rr_idx;
  assign gnt   = (state_q == LOCKED | found) & ~full & ~kill;
  assign issue = gnt & slc_ready_i;
  assign slc_valid_o     = gnt;
  assign req_ready_o     = issue ? NumReq'(1) << sel : '0;
  assign slc_operands_o  = gnt ? req_operands_i[32'(sel)*NumOperands*Width +: NumOperands*Width] : '0;
  assign slc_op_o        = gnt ? req_op_i[32'(sel)*4 +: 4] : '0;
  assign slc_rnd_mode_o  = gnt ? req_rnd_mode_i[32'(sel)*3 +: 3] : '0;
  assign slc_op_mod_o    = gnt & req_op_mod_i[sel];
  assign slc_vectorial_o = gnt & req_vectorial_i[sel];
  assign slc_tag_o       = gnt ? {sel, req_tag_i[32'(sel)*TagWidth +: TagWidth]} : '0;
  // IDs that decode past NumReq have no owner: accept and discard them
  assign id    = slc_tag_i[TagWidth +: IdW];
  assign oh    = IdN'(1) << id;
  assign id_ok = |oh[NumReq-1:0];
  assign rsp_valid_o     = kill ? '0 : oh[NumReq-1:0] & {NumReq{slc_out_valid_i}};
  assign slc_out_ready_o = kill | ~id_ok | |(oh[NumReq-1:0] & rsp_ready_i);
  assign rsp_result_o    = slc_result_i;
  assign rsp_status_o    = slc_status_i;
  assign rsp_tag_o       = slc_tag_i[TagWidth-1:0];
  assign rsp_hs = slc_out_valid_i & slc_out_ready_o;
  assign dec    = rsp_hs & (out_q != 4'd0);
  always_comb begin
    state_d = flush_i ? IDLE : issue ? IDLE : gnt ? LOCKED : state_q;
    lock_d  = gnt & ~issue ? sel : lock_q;
    ptr_d   = issue ? (sel == IdW'(NumReq-1) ? '0 : sel + 1'b1) : ptr_q;
    out_d   = flush_i ? 4'd0 : issue & ~dec ? out_q + 4'd1 : dec & ~issue ? out_q - 4'd1 : out_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
      ptr_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
    end
  end
  assign outstanding_o = out_q;
  assign busy_o = (out_q != 4'd0) | (state_q == LOCKED);
endmodule
